// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, divide-sequencer states and the
// predicate for instructions that depend on HI/LO or the divider.
package alu_pkg;

  typedef enum logic [3:0] {
    FN_ADD  = 4'b0000,
    FN_SUB  = 4'b0001,
    FN_AND  = 4'b0010,
    FN_OR   = 4'b0011,
    FN_DIVU = 4'b0100,
    FN_SLT  = 4'b0101,
    FN_SLL  = 4'b0110,
    FN_MFHI = 4'b1000,
    FN_MFLO = 4'b1001
  } alu_fn_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    COMMIT = 2'b10
  } div_state_e;

  // True for the codes that must wait while a divide is in flight.
  function automatic logic uses_hilo(input logic [3:0] fn);
    return (fn == FN_DIVU) || (fn == FN_MFHI) || (fn == FN_MFLO);
  endfunction

endpackage

// File: rtl/hilo_div_ctrl_if.sv
// Pipeline-side bundle of the HI/LO divide controller: instruction inputs
// from the pipeline (master) and busy/stall/done/HI/LO back to it.
interface hilo_div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       signal;
  logic             valid;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output signal, valid, op_a, op_b,
    input  busy, stall, done, hi_out, lo_out
  );

  modport slave (
    input  signal, valid, op_a, op_b,
    output busy, stall, done, hi_out, lo_out
  );
endinterface

// File: rtl/div_iter_core.sv
// One step of an unsigned restoring divide: shift {rem,quo} left by one and
// subtract the divisor when it fits, setting the new quotient bit.
module div_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  // Partial remainder needs one extra bit so the compare never overflows.
  logic [WIDTH:0] shifted_s;

  // Compare/subtract step; rem stays below divisor so the result fits WIDTH bits.
  always_comb begin
    shifted_s = {rem_in, quo_in[WIDTH-1]};
    rem_out   = shifted_s[WIDTH-1:0];
    quo_out   = {quo_in[WIDTH-2:0], 1'b0};
    if (shifted_s >= {1'b0, divisor}) begin
      rem_out = WIDTH'(shifted_s - {1'b0, divisor});
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = shifted_s[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_div_ctrl.sv
// DIVU sequencer and HI/LO owner: one quotient bit per cycle, remainder->HI,
// quotient->LO, plus the pipeline stall. Define DIV_ZERO_FAST_EN for a 1-cycle divide by zero.
module hilo_div_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  hilo_div_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_r;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             done_r;
  logic [WIDTH-1:0] rem_nxt_s;
  logic [WIDTH-1:0] quo_nxt_s;
  logic             busy_s;
  logic             accept_s;

  div_iter_core #(.WIDTH(WIDTH)) u_iter (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .divisor (divisor_r),
    .rem_out (rem_nxt_s),
    .quo_out (quo_nxt_s)
  );

  assign busy_s   = (state_r != IDLE);
  assign accept_s = bus.valid & (bus.signal == FN_DIVU);

  // Divide FSM, iteration counter, operand latches and HI/LO commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      count_r   <= {CNT_W{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      quo_r     <= {WIDTH{1'b0}};
      divisor_r <= {WIDTH{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            // quo starts as the dividend; its bits shift into rem one per step
            quo_r     <= bus.op_a;
            rem_r     <= {WIDTH{1'b0}};
            divisor_r <= bus.op_b;
            count_r   <= {CNT_W{1'b0}};
`ifdef DIV_ZERO_FAST_EN
            state_r   <= (bus.op_b == {WIDTH{1'b0}}) ? COMMIT : RUN;
`else
            state_r   <= RUN;
`endif
          end
        end
        RUN: begin
          rem_r   <= rem_nxt_s;
          quo_r   <= quo_nxt_s;
          count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (count_r == LAST_CNT) begin
            hi_r    <= rem_nxt_s;
            lo_r    <= quo_nxt_s;
            done_r  <= 1'b1;
            state_r <= IDLE;
          end
        end
`ifdef DIV_ZERO_FAST_EN
        COMMIT: begin
          hi_r    <= quo_r;
          lo_r    <= {WIDTH{1'b1}};
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
`endif
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_s;
  assign bus.stall  = bus.valid & busy_s & uses_hilo(bus.signal);
  assign bus.done   = done_r;
  assign bus.hi_out = hi_r;
  assign bus.lo_out = lo_r;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl: table of known divides, random divides
// against a plain-arithmetic model, and hand sequences for stall/back-to-back/reset.
module tb_hilo_div_ctrl;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  hilo_div_ctrl_if #(.WIDTH(W)) bus ();

  hilo_div_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_cycles(input logic [W-1:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == 0) ? 1 : W;
`else
    return W;
`endif
  endfunction

  task automatic drive(input logic v, input logic [3:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.valid  = v;
    bus.signal = fn;
    bus.op_a   = a;
    bus.op_b   = b;
  endtask

  // Entered at the negedge just after the accept edge, with DIVU withdrawn.
  task automatic wait_done(input string nm, input logic [W-1:0] eh, input logic [W-1:0] el, input int ecyc);
    logic [W-1:0] h0, l0;
    int  cyc;
    bit  moved, early;
    h0 = bus.hi_out;
    l0 = bus.lo_out;
    cyc = 0;
    moved = 0;
    early = 0;
    while (bus.busy && cyc < 200) begin
      cyc++;
      if (bus.hi_out !== h0 || bus.lo_out !== l0) moved = 1;
      if (bus.done) early = 1;
      @(negedge clk);
    end
    chk({nm, " busy cycles"}, cyc, ecyc);
    chk({nm, " hilo held"}, moved, 0);
    chk({nm, " done while busy"}, early, 0);
    chk({nm, " done pulse"}, bus.done, 1);
    chk({nm, " hi"}, bus.hi_out, eh);
    chk({nm, " lo"}, bus.lo_out, el);
    @(negedge clk);
    chk({nm, " done cleared"}, bus.done, 0);
  endtask

  task automatic run_div(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el);
    @(negedge clk);
    drive(1'b1, FN_DIVU, a, b);
    #1 chk({nm, " idle no stall"}, bus.stall, 0);
    @(negedge clk);
    drive(1'b0, FN_ADD, 0, 0);
    wait_done(nm, eh, el, exp_cycles(b));
  endtask

  initial begin
    logic [W-1:0] a, b, mh, ml;
    int cyc;

    vecs[0] = '{32'd100, 32'd7, 32'd2, 32'd14};
    vecs[1] = '{32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF};
    vecs[2] = '{32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF};
    vecs[3] = '{32'd9, 32'd3, 32'd0, 32'd3};
    vecs[4] = '{32'd5, 32'd9, 32'd5, 32'd0};
    vecs[5] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF};
    vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    vecs[7] = '{32'd0, 32'd5, 32'd0, 32'd0};
    vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1};

    // Reset state
    drive(1'b1, FN_MFHI, 0, 0);
    @(negedge clk);
    #1;
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset hi", bus.hi_out, 0);
    chk("reset lo", bus.lo_out, 0);
    chk("reset stall", bus.stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, FN_ADD, 0, 0);

    for (int i = 0; i < 9; i++)
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // Random divides against the arithmetic definition
    for (int k = 0; k < 16; k++) begin
      a = $urandom;
      if (k % 5 == 4) b = 0;
      else if (k % 2 == 1) b = $urandom_range(1, 1000);
      else b = $urandom >> $urandom_range(0, 28);
      if (b == 0) begin
        mh = a;
        ml = {W{1'b1}};
      end else begin
        mh = a % b;
        ml = a / b;
      end
      run_div($sformatf("rand%0d", k), a, b, mh, ml);
    end

    // Unrelated codes never stall; MFHI from cycle 5 stalls until done
    @(negedge clk);
    drive(1'b1, FN_DIVU, 100, 7);
    @(negedge clk);
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      cyc++;
      if (cyc == 1) drive(1'b1, FN_ADD, 3, 4);
      else if (cyc == 2) drive(1'b1, FN_SLT, 3, 4);
      else if (cyc == 3) drive(1'b1, FN_SLL, 3, 4);
      else if (cyc == 4) drive(1'b0, FN_MFLO, 0, 0);
      else drive(1'b1, FN_MFHI, 0, 0);
      #1;
      if (cyc < 5) chk($sformatf("no false stall c%0d", cyc), bus.stall, 0);
      else chk($sformatf("mfhi stall c%0d", cyc), bus.stall, 1);
      @(negedge clk);
    end
    #1;
    chk("mfhi busy cycles", cyc, W);
    chk("mfhi done-cycle stall", bus.stall, 0);
    chk("mfhi done-cycle done", bus.done, 1);
    chk("mfhi done-cycle hi", bus.hi_out, 2);
    @(negedge clk);
    drive(1'b0, FN_ADD, 0, 0);

    // Back-to-back DIVU: second one stalled, accepted in the done cycle
    @(negedge clk);
    drive(1'b1, FN_DIVU, 100, 7);
    @(negedge clk);
    drive(1'b1, FN_DIVU, 32'hFFFF_FFFF, 16);
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      cyc++;
      #1 chk($sformatf("b2b stall c%0d", cyc), bus.stall, 1);
      @(negedge clk);
    end
    #1;
    chk("b2b first busy cycles", cyc, W);
    chk("b2b done-cycle stall", bus.stall, 0);
    chk("b2b first done", bus.done, 1);
    chk("b2b first hi", bus.hi_out, 2);
    chk("b2b first lo", bus.lo_out, 14);
    @(negedge clk);
    drive(1'b0, FN_ADD, 0, 0);
    wait_done("b2b second", 15, 32'h0FFF_FFFF, W);

    // Reset at count 10 aborts the divide and clears HI/LO
    @(negedge clk);
    drive(1'b1, FN_DIVU, 1000, 7);
    @(negedge clk);
    drive(1'b0, FN_ADD, 0, 0);
    repeat (10) @(negedge clk);
    chk("pre-reset busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid-reset busy", bus.busy, 0);
    chk("mid-reset hi", bus.hi_out, 0);
    chk("mid-reset lo", bus.lo_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (bus.done || bus.busy) begin
        chk("post-reset no done/busy", {bus.done, bus.busy}, 0);
        break;
      end
    end
    chk("post-reset done", bus.done, 0);
    run_div("post-reset 9/3", 9, 3, 0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
